fsync_tree_node: RTL and testbench
==================================

# fsync_tree_node

Responder end of the fractal-sync request/wake protocol. It sits at one level of the fractal-sync tree and accepts sync requests from two child ports, which are tiles or lower nodes. When both children have arrived with matching `aggr`/`id_req`, it does one of two things:
- wakes both children itself, if this level is the top of the requested aggregation;
- otherwise forwards a single merged request to its parent, waits for the parent's wake, and fans that wake back down to both children.

## Interface
Parameters:
- `AGGR_W`, default `magia_tile_pkg::FSYNC_AGGR_W`: width of the aggregation mask on child ports. The parent port uses `AGGR_W-1`, and `AGGR_W` must be ≥ 2.
- `ID_W`, default `magia_tile_pkg::FSYNC_ID_W`: barrier id width, identical on child and parent ports.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. One clock; reset is asynchronous and active-high.
- `clear_i`, in, 1: synchronous clear; same effect as reset.
- `c_sync_i[2]`, in, 1 each: child sync pulse.
- `c_aggr_i[2]`, in, `AGGR_W` each: child aggregation mask.
- `c_id_i[2]`, in, `ID_W` each: child barrier id.
- `c_wake_o[2]`, out, 1 each: wake pulse to child.
- `c_error_o[2]`, out, 1 each: error pulse to child.
- `p_sync_o`, out, 1: parent sync pulse.
- `p_aggr_o`, out, `AGGR_W-1`: forwarded mask.
- `p_id_o`, out, `ID_W`: forwarded id.
- `p_wake_i`, in, 1: parent wake.
- `p_error_i`, in, 1: parent error.

## Operation
Request acceptance:
- A request is the single-cycle `c_sync_i[k]=1` pulse, with `aggr`/`id` valid in the same cycle.
- On acceptance, child `k` sets `pend[k]` and latches its `aggr`/`id`.

State machine states: IDLE, HALF, FWD, WAIT_P, WAKE.
- **IDLE**
  - One child syncs: go to HALF.
  - Both children sync in the same cycle with matching fields: evaluate the request directly (see "Evaluation" below).
- **HALF**
  - The other child syncs: compare its `aggr`/`id` with the latched values.
  - Match: evaluate the request.
  - Mismatch: pulse `c_error_o` on both children, clear pending, go to IDLE.
- **Evaluation**
  - `aggr == 1` (this level is the top): go to WAKE.
  - `aggr[AGGR_W-1:1] != 0`: go to FWD.
- **FWD**
  - Outputs: `p_sync_o=1` for exactly one cycle, `p_aggr_o=aggr[AGGR_W-1:1]`, `p_id_o=id`.
  - Next state: WAIT_P.
- **WAIT_P**
  - `p_wake_i`: go to WAKE.
  - `p_error_i`: pulse `c_error_o` on both children, go to IDLE. `p_error_i` takes priority over `p_wake_i` when both are asserted.
- **WAKE**
  - Outputs: `c_wake_o=2'b11` for one cycle, clear pending.
  - Next state: IDLE.

Error rules (always a one-cycle pulse on `c_error_o[k]` of the offending child only, unless stated otherwise):
- `c_aggr_i == 0`: error to the sender; request is not accepted.
- Already-pending child syncs again in HALF: error to that child; the original pending request is kept.
- Any child sync during FWD, WAIT_P or WAKE: error to the sender; the in-flight barrier is unaffected.
- Both children sync in IDLE with mismatched fields: error to both, stay in IDLE.

Output registration and reset:
- All outputs are registered.
- Reset/clear values: `c_wake_o=0`, `c_error_o=0`, `p_sync_o=0`, `p_aggr_o=0`, `p_id_o=0`, state IDLE, pending cleared.
- `p_aggr_o`/`p_id_o` hold their last forwarded value until the next forward.

## Timing
- Latencies are measured from the edge that samples the triggering input:
  - Root barrier: the second child's sync is sampled at edge N; `c_wake_o=11` is high during the cycle after edge N+1.
  - Forwarded barrier: `p_sync_o` is high in the cycle after edge N+1.
  - Parent wake sampled at edge M: `c_wake_o` is high after edge M+1.
- Reset or clear in the middle of a barrier drops it silently. No wake and no error are issued. A late `p_wake_i` arriving in IDLE is ignored.
- Child syncs arriving on the same edge that leaves WAKE for IDLE are rejected as busy. After that, a fresh barrier can start on the next cycle.

## Structure
- Shared package `fsync_pkg`:
  - state enum `fsync_node_state_e`;
  - struct `fsync_req_t {aggr, id}`, parameterised through localparams derived from `magia_tile_pkg` widths.
- Natural sub-module: `fsync_req_latch`, instantiated twice (one per child). It holds `pend`, latched `aggr`/`id`, and per-child error detection.
- The FSM, comparison and fan-out logic live in the top level.

## Test plan
- **Root barrier:** child0 `aggr=1,id=3`; three cycles later child1 `aggr=1,id=3` → `c_wake_o=11` one cycle later; no `p_sync_o`.
- **Forwarded barrier:** both children `aggr=4'b0110,id=5` in the same cycle → `p_sync_o` one cycle later with `p_aggr_o=3'b011`, `p_id_o=5`; `p_wake_i` pulse → `c_wake_o=11` one cycle later.
- **Mismatch:** child0 `id=2`, child1 `id=7` → `c_error_o=11`, no wake, returns to IDLE; a following valid pair completes normally.
- **Busy/duplicate:**
  - During WAIT_P, child0 re-syncs → `c_error_o=01` only; barrier still completes on `p_wake_i`.
  - In HALF, the pending child re-syncs → error to that child; its original request is kept.
- **Parent error:** `p_wake_i` and `p_error_i` together in WAIT_P → `c_error_o=11`, `c_wake_o=00`.
- **Reset mid-barrier:** assert `rst_i` in WAIT_P → all outputs 0 immediately; a later `p_wake_i` produces no wake.

Source files
------------

// File: rtl/fsync_pkg.sv
// Shared widths, state encoding and request record for the fractal-sync tree.
// magia_tile_pkg lives here too so the tile widths resolve before fsync_pkg uses them.
package magia_tile_pkg;
    localparam int unsigned FSYNC_AGGR_W = 4;
    localparam int unsigned FSYNC_ID_W   = 8;
endpackage

package fsync_pkg;
    localparam int unsigned FSYNC_REQ_AGGR_W = magia_tile_pkg::FSYNC_AGGR_W;
    localparam int unsigned FSYNC_REQ_ID_W   = magia_tile_pkg::FSYNC_ID_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALF,
        ST_FWD,
        ST_WAIT_P,
        ST_WAKE
    } fsync_node_state_e;

    typedef struct packed {
        logic [FSYNC_REQ_AGGR_W-1:0] aggr;
        logic [FSYNC_REQ_ID_W-1:0]   id;
    } fsync_req_t;
endpackage

// File: rtl/fsync_req_latch.sv
// Per-child request holder: pending flag, latched aggr/id and rejection of
// zero-mask, duplicate and busy-time syncs.
module fsync_req_latch
    import fsync_pkg::*;
#(
    parameter int unsigned AGGR_W = magia_tile_pkg::FSYNC_AGGR_W,
    parameter int unsigned ID_W   = magia_tile_pkg::FSYNC_ID_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_sync,
    input  logic [AGGR_W-1:0] i_aggr,
    input  logic [ID_W-1:0]   i_id,
    input  logic              i_busy,
    input  logic              i_load,
    input  logic              i_clr_pend,
    output logic              o_pend,
    output logic [AGGR_W-1:0] o_aggr,
    output logic [ID_W-1:0]   o_id,
    output logic              o_valid,
    output logic              o_err
);
    logic              r_pend;
    logic [AGGR_W-1:0] r_aggr;
    logic [ID_W-1:0]   r_id;

    // A pending child syncing again is a duplicate; the held request stays intact.
    assign o_err   = i_sync & ((i_aggr == '0) | i_busy | r_pend);
    assign o_valid = i_sync & ~o_err;
    assign o_pend  = r_pend;
    assign o_aggr  = r_aggr;
    assign o_id    = r_id;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= 1'b0;
            r_aggr <= '0;
            r_id   <= '0;
        end else if (i_clear) begin
            r_pend <= 1'b0;
            r_aggr <= '0;
            r_id   <= '0;
        end else if (i_clr_pend) begin
            r_pend <= 1'b0;
        end else if (i_load) begin
            r_pend <= 1'b1;
            r_aggr <= i_aggr;
            r_id   <= i_id;
        end
    end
endmodule

// File: rtl/fsync_tree_node.sv
// One level of the fractal-sync tree: pairs two child requests, then wakes them
// locally or forwards a merged request upward and fans the parent's wake back down.
module fsync_tree_node
    import fsync_pkg::*;
#(
    parameter int unsigned AGGR_W = magia_tile_pkg::FSYNC_AGGR_W,
    parameter int unsigned ID_W   = magia_tile_pkg::FSYNC_ID_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic [1:0]        c_sync_i,
    input  logic [AGGR_W-1:0] c_aggr_i [2],
    input  logic [ID_W-1:0]   c_id_i [2],
    output logic [1:0]        c_wake_o,
    output logic [1:0]        c_error_o,
    output logic              p_sync_o,
    output logic [AGGR_W-2:0] p_aggr_o,
    output logic [ID_W-1:0]   p_id_o,
    input  logic              p_wake_i,
    input  logic              p_error_i
);
    fsync_node_state_e r_state, w_state_nxt;

    logic [1:0]        w_pend, w_valid, w_err_child, w_load, w_arr;
    logic [AGGR_W-1:0] w_aggr_q [2];
    logic [ID_W-1:0]   w_id_q [2];
    logic              w_busy, w_clr_pend, w_psync_nxt;
    logic [1:0]        w_wake_nxt, w_err_nxt;

    logic              r_psync;
    logic [1:0]        r_wake, r_err;
    logic [AGGR_W-2:0] r_paggr;
    logic [ID_W-1:0]   r_pid;

    assign w_busy = (r_state == ST_FWD) | (r_state == ST_WAIT_P) | (r_state == ST_WAKE);
    assign w_arr  = w_valid & ~w_pend;

    for (genvar k = 0; k < 2; k++) begin : g_child
        fsync_req_latch #(.AGGR_W(AGGR_W), .ID_W(ID_W)) u_req (
            .i_clk      (clk_i),
            .i_rst      (rst_i),
            .i_clear    (clear_i),
            .i_sync     (c_sync_i[k]),
            .i_aggr     (c_aggr_i[k]),
            .i_id       (c_id_i[k]),
            .i_busy     (w_busy),
            .i_load     (w_load[k]),
            .i_clr_pend (w_clr_pend),
            .o_pend     (w_pend[k]),
            .o_aggr     (w_aggr_q[k]),
            .o_id       (w_id_q[k]),
            .o_valid    (w_valid[k]),
            .o_err      (w_err_child[k])
        );
    end

    // Any mask bit above this level means the barrier spans further up the tree.
    function automatic fsync_node_state_e eval_st(input logic [AGGR_W-1:0] a);
        return (a[AGGR_W-1:1] != '0) ? ST_FWD : ST_WAKE;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 2'b00;
        w_clr_pend  = 1'b0;
        w_wake_nxt  = 2'b00;
        w_err_nxt   = w_err_child;
        w_psync_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (&w_valid) begin
                    if (c_aggr_i[0] == c_aggr_i[1] && c_id_i[0] == c_id_i[1]) begin
                        w_load      = 2'b11;
                        w_state_nxt = eval_st(c_aggr_i[0]);
                    end else begin
                        w_err_nxt = 2'b11;
                    end
                end else if (|w_valid) begin
                    w_load      = w_valid;
                    w_state_nxt = ST_HALF;
                end
            end
            ST_HALF: begin
                if (|w_arr) begin
                    if (c_aggr_i[w_arr[1]] == w_aggr_q[w_pend[1]] &&
                        c_id_i[w_arr[1]] == w_id_q[w_pend[1]]) begin
                        w_load      = w_arr;
                        w_state_nxt = eval_st(w_aggr_q[w_pend[1]]);
                    end else begin
                        w_err_nxt   = 2'b11;
                        w_clr_pend  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_FWD: begin
                w_psync_nxt = 1'b1;
                w_state_nxt = ST_WAIT_P;
            end
            ST_WAIT_P: begin
                if (p_error_i) begin
                    w_err_nxt   = 2'b11;
                    w_clr_pend  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (p_wake_i) begin
                    w_state_nxt = ST_WAKE;
                end
            end
            ST_WAKE: begin
                w_wake_nxt  = 2'b11;
                w_clr_pend  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_wake  <= 2'b00;
            r_err   <= 2'b00;
            r_psync <= 1'b0;
            r_paggr <= '0;
            r_pid   <= '0;
        end else if (clear_i) begin
            r_state <= ST_IDLE;
            r_wake  <= 2'b00;
            r_err   <= 2'b00;
            r_psync <= 1'b0;
            r_paggr <= '0;
            r_pid   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wake  <= w_wake_nxt;
            r_err   <= w_err_nxt;
            r_psync <= w_psync_nxt;
            if (w_psync_nxt) begin
                r_paggr <= w_aggr_q[0][AGGR_W-1:1];
                r_pid   <= w_id_q[0];
            end
        end
    end

    assign c_wake_o  = r_wake;
    assign c_error_o = r_err;
    assign p_sync_o  = r_psync;
    assign p_aggr_o  = r_paggr;
    assign p_id_o    = r_pid;
endmodule

// File: tb/tb_fsync_tree_node.sv
// Directed vector bench for fsync_tree_node: cycle-by-cycle table plus
// hand sequences for parent error, reset and clear in mid-barrier.
module tb_fsync_tree_node;
    logic       clk = 1'b0;
    logic       rst, clear;
    logic [1:0] c_sync;
    logic [3:0] c_aggr [2];
    logic [7:0] c_id [2];
    logic [1:0] c_wake, c_error;
    logic       p_sync, p_wake, p_error;
    logic [2:0] p_aggr;
    logic [7:0] p_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsync_tree_node #(.AGGR_W(4), .ID_W(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (clear),
        .c_sync_i  (c_sync),
        .c_aggr_i  (c_aggr),
        .c_id_i    (c_id),
        .c_wake_o  (c_wake),
        .c_error_o (c_error),
        .p_sync_o  (p_sync),
        .p_aggr_o  (p_aggr),
        .p_id_o    (p_id),
        .p_wake_i  (p_wake),
        .p_error_i (p_error)
    );

    typedef struct {
        logic [1:0] s;
        logic [3:0] a0, a1;
        logic [7:0] i0, i1;
        logic       pw, pe;
        logic [1:0] wake, err;
        logic       ps;
        logic [2:0] pa;
        logic [7:0] pi;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic [1:0] s, input logic [3:0] a0, input logic [3:0] a1,
                               input logic [7:0] i0, input logic [7:0] i1,
                               input logic pw, input logic pe,
                               input logic [1:0] wake, input logic [1:0] err,
                               input logic ps, input logic [2:0] pa, input logic [7:0] pi);
        vec_t t;
        t.s = s; t.a0 = a0; t.a1 = a1; t.i0 = i0; t.i1 = i1; t.pw = pw; t.pe = pe;
        t.wake = wake; t.err = err; t.ps = ps; t.pa = pa; t.pi = pi;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] wake, input logic [1:0] err,
                            input logic ps, input logic [2:0] pa, input logic [7:0] pi);
        chk({tag, ".c_wake"},  32'(c_wake),  32'(wake));
        chk({tag, ".c_error"}, 32'(c_error), 32'(err));
        chk({tag, ".p_sync"},  32'(p_sync),  32'(ps));
        chk({tag, ".p_aggr"},  32'(p_aggr),  32'(pa));
        chk({tag, ".p_id"},    32'(p_id),    32'(pi));
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic apply(input logic [1:0] s, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [7:0] i0, input logic [7:0] i1, input logic pw, input logic pe);
        @(negedge clk);
        c_sync = s; c_aggr[0] = a0; c_aggr[1] = a1; c_id[0] = i0; c_id[1] = i1;
        p_wake = pw; p_error = pe;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; c_sync = 2'b00; p_wake = 1'b0; p_error = 1'b0;
        c_aggr[0] = '0; c_aggr[1] = '0; c_id[0] = '0; c_id[1] = '0;

        // root barrier
        vq.push_back(v(2'b01, 4'd1, 4'd0, 8'd3, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd0, 8'd0));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd0, 8'd0));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd0, 8'd0));
        vq.push_back(v(2'b10, 4'd0, 4'd1, 8'd0, 8'd3, 0, 0, 2'b00, 2'b00, 0, 3'd0, 8'd0));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b11, 2'b00, 0, 3'd0, 8'd0));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd0, 8'd0));
        // forwarded barrier, both children together
        vq.push_back(v(2'b11, 4'd6, 4'd6, 8'd5, 8'd5, 0, 0, 2'b00, 2'b00, 0, 3'd0, 8'd0));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b00, 2'b00, 1, 3'd3, 8'd5));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd3, 8'd5));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 1, 0, 2'b00, 2'b00, 0, 3'd3, 8'd5));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b11, 2'b00, 0, 3'd3, 8'd5));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd3, 8'd5));
        // id mismatch in HALF, then a valid pair
        vq.push_back(v(2'b01, 4'd2, 4'd0, 8'd2, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd3, 8'd5));
        vq.push_back(v(2'b10, 4'd0, 4'd2, 8'd0, 8'd7, 0, 0, 2'b00, 2'b11, 0, 3'd3, 8'd5));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd3, 8'd5));
        vq.push_back(v(2'b11, 4'd1, 4'd1, 8'd9, 8'd9, 0, 0, 2'b00, 2'b00, 0, 3'd3, 8'd5));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b11, 2'b00, 0, 3'd3, 8'd5));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd3, 8'd5));
        // busy sync in WAIT_P, then syncs on the WAKE->IDLE edge, then a fresh HALF
        vq.push_back(v(2'b11, 4'd2, 4'd2, 8'd4, 8'd4, 0, 0, 2'b00, 2'b00, 0, 3'd3, 8'd5));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b00, 2'b00, 1, 3'd1, 8'd4));
        vq.push_back(v(2'b01, 4'd1, 4'd0, 8'd4, 8'd0, 0, 0, 2'b00, 2'b01, 0, 3'd1, 8'd4));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 1, 0, 2'b00, 2'b00, 0, 3'd1, 8'd4));
        vq.push_back(v(2'b11, 4'd1, 4'd1, 8'd1, 8'd1, 0, 0, 2'b11, 2'b11, 0, 3'd1, 8'd4));
        vq.push_back(v(2'b01, 4'd1, 4'd0, 8'd1, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd1, 8'd4));
        // duplicate from the pending child keeps the original request
        vq.push_back(v(2'b01, 4'd3, 4'd0, 8'd8, 8'd0, 0, 0, 2'b00, 2'b01, 0, 3'd1, 8'd4));
        vq.push_back(v(2'b10, 4'd0, 4'd1, 8'd0, 8'd1, 0, 0, 2'b00, 2'b00, 0, 3'd1, 8'd4));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b11, 2'b00, 0, 3'd1, 8'd4));
        // zero mask rejected, not accepted
        vq.push_back(v(2'b01, 4'd0, 4'd0, 8'd6, 8'd0, 0, 0, 2'b00, 2'b01, 0, 3'd1, 8'd4));
        vq.push_back(v(2'b10, 4'd0, 4'd1, 8'd0, 8'd6, 0, 0, 2'b00, 2'b00, 0, 3'd1, 8'd4));
        vq.push_back(v(2'b01, 4'd1, 4'd0, 8'd6, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd1, 8'd4));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b11, 2'b00, 0, 3'd1, 8'd4));
        // simultaneous mismatched pair in IDLE stays in IDLE
        vq.push_back(v(2'b11, 4'd1, 4'd2, 8'd0, 8'd0, 0, 0, 2'b00, 2'b11, 0, 3'd1, 8'd4));
        vq.push_back(v(2'b01, 4'd1, 4'd0, 8'd0, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd1, 8'd4));
        vq.push_back(v(2'b10, 4'd0, 4'd1, 8'd0, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd1, 8'd4));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b11, 2'b00, 0, 3'd1, 8'd4));
        // mask with bit 0 and upper bits set still forwards
        vq.push_back(v(2'b11, 4'hB, 4'hB, 8'd2, 8'd2, 0, 0, 2'b00, 2'b00, 0, 3'd1, 8'd4));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b00, 2'b00, 1, 3'd5, 8'd2));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 1, 0, 2'b00, 2'b00, 0, 3'd5, 8'd2));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b11, 2'b00, 0, 3'd5, 8'd2));
        vq.push_back(v(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 0, 0, 2'b00, 2'b00, 0, 3'd5, 8'd2));

        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 2'b00, 2'b00, 1'b0, 3'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[n]) begin
            apply(vq[n].s, vq[n].a0, vq[n].a1, vq[n].i0, vq[n].i1, vq[n].pw, vq[n].pe);
            chk_outs($sformatf("vec%0d", n), vq[n].wake, vq[n].err, vq[n].ps, vq[n].pa, vq[n].pi);
        end

        // parent error wins over simultaneous wake; pending is dropped
        apply(2'b11, 4'd4, 4'd4, 8'd9, 8'd9, 0, 0);
        chk_outs("perr.fwd", 2'b00, 2'b00, 1'b0, 3'd5, 8'd2);
        idle();
        chk_outs("perr.psync", 2'b00, 2'b00, 1'b1, 3'd2, 8'd9);
        apply(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 1, 1);
        chk_outs("perr.err", 2'b00, 2'b11, 1'b0, 3'd2, 8'd9);
        idle();
        chk_outs("perr.after", 2'b00, 2'b00, 1'b0, 3'd2, 8'd9);
        apply(2'b01, 4'd1, 4'd0, 8'd1, 8'd0, 0, 0);
        chk_outs("perr.half", 2'b00, 2'b00, 1'b0, 3'd2, 8'd9);
        apply(2'b10, 4'd0, 4'd1, 8'd0, 8'd1, 0, 0);
        idle();
        chk_outs("perr.rewake", 2'b11, 2'b00, 1'b0, 3'd2, 8'd9);

        // reset in WAIT_P: outputs drop at once, late parent wake ignored
        apply(2'b11, 4'd4, 4'd4, 8'd10, 8'd10, 0, 0);
        idle();
        chk_outs("rst.psync", 2'b00, 2'b00, 1'b1, 3'd2, 8'd10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outs("rst.async", 2'b00, 2'b00, 1'b0, 3'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 1, 0);
        chk_outs("rst.latewake", 2'b00, 2'b00, 1'b0, 3'd0, 8'd0);
        idle();
        chk_outs("rst.nowake", 2'b00, 2'b00, 1'b0, 3'd0, 8'd0);

        // clear in HALF drops the pending request
        apply(2'b01, 4'd1, 4'd0, 8'd2, 8'd0, 0, 0);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        apply(2'b10, 4'd0, 4'd1, 8'd0, 8'd2, 0, 0);
        idle();
        chk_outs("clr.nowake", 2'b00, 2'b00, 1'b0, 3'd0, 8'd0);
        apply(2'b01, 4'd1, 4'd0, 8'd2, 8'd0, 0, 0);
        idle();
        chk_outs("clr.wake", 2'b11, 2'b00, 1'b0, 3'd0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
